// File: rtl/etherframe_gen_if.sv
// AXI-Stream byte-lane bus carrying generated Ethernet frames; first byte in the MSB lane.
// The generator drives the master side; the consumer drives tready.
interface etherframe_gen_if #(
    parameter int DATA_W = 32
) ();
    localparam int KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/etherframe_gen.sv
// Ethernet frame generator: latched header + patterned payload, zero-padded to MIN_FRAME, no FCS.
// Latency: first beat valid the cycle after an accepted i_start, then one beat per cycle.
// Backpressure: current beat held stable while tready=0; starts while busy are dropped, not queued.
module etherframe_gen #(
    parameter int DATA_W      = 32,
    parameter int MAX_PAYLOAD = 1500,
    parameter int MIN_FRAME   = 60,
    parameter int IFG_CYCLES  = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [47:0]      i_dest_mac,
    input  logic [47:0]      i_src_mac,
    input  logic [15:0]      i_ether_type,
    input  logic [10:0]      i_payload_len,
    input  logic [1:0]       i_pattern,
    input  logic [7:0]       i_fill_byte,
    etherframe_gen_if.master m_axis,
    output logic             o_busy,
    output logic             o_len_err,
    output logic [CNT_W-1:0] o_frame_cnt
);
    localparam int          KEEP_W   = DATA_W / 8;
    localparam int          LEN_W    = 16;
    localparam int          GAP_W    = 16;
    localparam logic [31:0] MAX_P    = 32'(MAX_PAYLOAD);
    localparam logic [31:0] MIN_F    = 32'(MIN_FRAME);
    localparam logic [31:0] KEEP_W32 = 32'(KEEP_W);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [47:0]      dest_q, dest_d;
    logic [47:0]      src_q, src_d;
    logic [15:0]      type_q, type_d;
    logic [1:0]       pattern_q, pattern_d;
    logic [7:0]       fill_q, fill_d;
    logic [LEN_W-1:0] plen_q, plen_d;
    logic [LEN_W-1:0] total_q, total_d;
    logic [LEN_W-1:0] base_q, base_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             len_err_q, len_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [31:0] req_len;
    logic [31:0] plen_new;
    logic [31:0] hdr_len;
    logic        len_over;
    logic        last_beat;
    logic [31:0] lane_idx;

    // Length arithmetic for a start request, evaluated against the live inputs.
    always_comb begin
        req_len  = 32'(i_payload_len);
        len_over = req_len > MAX_P;
        plen_new = len_over ? MAX_P : req_len;
        hdr_len  = plen_new + 32'd14;
    end

    // base_q is the byte offset of the current beat; the beat holding byte total-1 is the last.
    assign last_beat = (32'(base_q) + KEEP_W32) >= 32'(total_q);

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        src_d       = src_q;
        type_d      = type_q;
        pattern_d   = pattern_q;
        fill_d      = fill_q;
        plen_d      = plen_q;
        total_d     = total_q;
        base_d      = base_q;
        gap_d       = gap_q;
        len_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    dest_d    = i_dest_mac;
                    src_d     = i_src_mac;
                    type_d    = i_ether_type;
                    pattern_d = i_pattern;
                    fill_d    = i_fill_byte;
                    plen_d    = LEN_W'(plen_new);
                    total_d   = LEN_W'((hdr_len < MIN_F) ? MIN_F : hdr_len);
                    base_d    = '0;
                    len_err_d = len_over;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (m_axis.tready) begin
                    if (last_beat) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        if (IFG_CYCLES == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_W'(IFG_CYCLES - 1);
                        end
                    end else begin
                        base_d = base_q + LEN_W'(KEEP_W);
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            src_q       <= '0;
            type_q      <= '0;
            pattern_q   <= '0;
            fill_q      <= '0;
            plen_q      <= '0;
            total_q     <= '0;
            base_q      <= '0;
            gap_q       <= '0;
            len_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            src_q       <= src_d;
            type_q      <= type_d;
            pattern_q   <= pattern_d;
            fill_q      <= fill_d;
            plen_q      <= plen_d;
            total_q     <= total_d;
            base_q      <= base_d;
            gap_q       <= gap_d;
            len_err_q   <= len_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Byte at frame offset idx: header, then payload pattern, then zero padding.
    function automatic logic [7:0] frame_byte(input logic [31:0] idx);
        logic [7:0] p;
        frame_byte = 8'h00;
        p = 8'(idx - 32'd14);
        if (idx < 32'd6) begin
            frame_byte = 8'(dest_q >> (8 * (32'd5 - idx)));
        end else if (idx < 32'd12) begin
            frame_byte = 8'(src_q >> (8 * (32'd11 - idx)));
        end else if (idx == 32'd12) begin
            frame_byte = type_q[15:8];
        end else if (idx == 32'd13) begin
            frame_byte = type_q[7:0];
        end else if (idx < 32'(plen_q) + 32'd14) begin
            case (pattern_q)
                2'd0:    frame_byte = p;
                2'd1:    frame_byte = ~p;
                2'd2:    frame_byte = fill_q;
                default: frame_byte = 8'h00;
            endcase
        end
    endfunction

    // Beat contents derive only from registered state, so they cannot change during a stall.
    always_comb begin
        m_axis.tdata = '0;
        m_axis.tkeep = '0;
        lane_idx     = '0;
        for (int l = 0; l < KEEP_W; l++) begin
            lane_idx = 32'(base_q) + 32'(l);
            if (state_q == SEND && lane_idx < 32'(total_q)) begin
                m_axis.tdata[DATA_W-1-8*l -: 8] = frame_byte(lane_idx);
                m_axis.tkeep[KEEP_W-1-l]        = 1'b1;
            end
        end
    end

    assign m_axis.tvalid = (state_q == SEND);
    assign m_axis.tlast  = (state_q == SEND) && last_beat;
    assign o_busy        = (state_q != IDLE);
    assign o_len_err     = len_err_q;
    assign o_frame_cnt   = frame_cnt_q;
endmodule

// File: doc/etherframe_gen.md
Name: etherframe_gen

Overview:
Synthesisable, parametrised Ethernet frame generator with an AXI-Stream master output. It drives the receive side of the frame FIFO as a hardware traffic source for simulation and on-chip loopback. Each frame is built on the fly from latched header fields and a selectable payload pattern. Short frames are zero-padded to the Ethernet minimum, and the generator honours downstream backpressure and a programmable inter-frame gap. FCS is not generated.

Parameters:
DATA_W, 32, stream width in bits; multiple of 8, range 8..64; KEEP_W = DATA_W/8
MAX_PAYLOAD, 1500, largest payload in bytes; longer requests are clamped
MIN_FRAME, 60, minimum header+payload bytes (64 with FCS); shorter frames are zero-padded
IFG_CYCLES, 3, idle cycles after the last beat before a new start is accepted; 0 allowed
CNT_W, 16, width of the frame counter

Ports:
clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle request to send a frame; ignored while o_busy=1
i_dest_mac  in  48  destination MAC, latched on an accepted start
i_src_mac  in  48  source MAC, latched on an accepted start
i_ether_type  in  16  EtherType, latched on an accepted start
i_payload_len  in  11  payload bytes, latched on an accepted start
i_pattern  in  2  payload mode: 0 incrementing (i%256), 1 decrementing (255-i%256), 2 constant i_fill_byte, 3 all zero
i_fill_byte  in  8  byte used in mode 2, latched on an accepted start
o_tdata  out  DATA_W  frame data; first byte in the MSB lane
o_tkeep  out  KEEP_W  byte-lane enables, MSB-aligned
o_tvalid  out  1  data valid
o_tlast  out  1  last beat of the frame
i_tready  in  1  downstream ready
o_busy  out  1  high from an accepted start until the gap ends
o_len_err  out  1  one-cycle pulse when the latched length exceeded MAX_PAYLOAD
o_frame_cnt  out  CNT_W  count of completed frames

Behaviour:
- Reset (asynchronous, any state, including mid-frame): all outputs 0, FSM to IDLE, counter 0. A partial frame is abandoned; no tlast is issued.
- FSM IDLE:
  - i_start=1 latches all fields and sets plen = min(i_payload_len, MAX_PAYLOAD).
  - If the requested length exceeded MAX_PAYLOAD, o_len_err pulses on the next cycle.
  - total = max(14+plen, MIN_FRAME); beats = ceil(total/KEEP_W).
  - Goes to SEND. o_busy and o_tvalid rise on the cycle after i_start (latency 1).
- Frame byte map:
  - Bytes 0-5: dest MAC, MSB first. Bytes 6-11: src MAC. Bytes 12-13: EtherType.
  - Bytes 14..13+plen: payload per i_pattern, where i is the payload index.
  - Bytes 14+plen..total-1: 0x00 padding in every mode.
- Beat k carries bytes k*KEEP_W.. in descending lanes.
  - Lanes past total-1 have tdata=0 and keep=0.
  - All other beats have o_tkeep all-ones.
- FSM SEND, AXI-Stream rules:
  - o_tdata, o_tkeep and o_tlast are stable while o_tvalid=1 and i_tready=0.
  - o_tvalid never drops mid-frame.
  - A beat advances only when tvalid=1 and tready=1 on the same cycle.
  - o_tlast=1 only on beat beats-1.
  - On the tlast handshake: o_frame_cnt increments (wraps modulo 2^CNT_W) and o_tvalid falls the next cycle. The FSM goes to GAP, or to IDLE with o_busy=0 if IFG_CYCLES=0.
- FSM GAP:
  - Counts IFG_CYCLES cycles with o_tvalid=0 and o_busy=1, then goes to IDLE.
  - i_start during GAP or SEND is dropped; it is not queued.
- plen=0 is legal: header plus 46 bytes of zero padding.
- i_tready is a don't-care while o_tvalid=0.
- Back-to-back throughput: one beat per cycle when i_tready stays high.

Test Plan:
- DATA_W=32, default MACs, EtherType 0x0800, len=1500, mode 0, tready=1:
  - Expect 379 beats; beat0 0x00142201, beat1 0x23450014, beat2 0x226789AB, beat3 0x08000001.
  - Last beat 0xDADB0000 with tkeep 4'b1100 and tlast=1.
  - o_frame_cnt goes to 1.
- DATA_W=32, len=10, mode 0:
  - Expect 15 beats; beat3 0x08000001, beat5 0x06070809.
  - Beats 6..14 are 0x00000000 with tkeep 4'hF; tlast on beat 14.
- Backpressure: hold tready=0 for 5 cycles at beat 100 and at the tlast beat → tdata/tkeep/tlast unchanged during the stall, no beat skipped or duplicated, frame_cnt increments once.
- IFG_CYCLES=3: pulse i_start during SEND and again during GAP → both ignored. o_busy falls exactly 3 cycles after tvalid falls, then a start is accepted with 1-cycle latency.
- DATA_W=64, len=46, mode 2 with fill 0xA5 → 8 beats; last beat 0xA5A5A5A500000000 with tkeep 8'hF0. Repeat with len=1600 → clamped to 1500, o_len_err pulses once, 190 beats.
- Assert i_rst_n=0 at beat 50 → all outputs 0 immediately, no tlast. After release, a new start produces a complete correct frame and o_frame_cnt restarts at 1.
